// File: rtl/mem_stage.sv
// Memory-access stage: registers the execute bus, holds load data across stalls.
// Define MEM_FWD_EN to drive the decode forwarding bus and the load flag.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id,
  output logic                    mem_is_load
);

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } hold_e;

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
  hold_e                   hold_st;
  logic [31:0]             rdata_buf;

  logic        bubble;
  logic        capture;
  logic        new_entry;
  logic        is_load;
  logic        rdata_vld;
  logic [31:0] load_data;

  logic [31:0] pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [31:0] rf_wdata;
  logic        unused_stall;

  assign bubble    = stall[3] & ~stall[4];
  assign capture   = ~stall[3];
  assign new_entry = bubble | capture;

  assign unused_stall = ^{stall[5], stall[2:0]};

  assign {pc, data_ram_en, data_ram_wen, sel_rf_res,
          rf_we, rf_waddr, ex_result} = ex_to_mem_bus_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_to_mem_bus_r <= '0;
      hold_st         <= LIVE;
      rdata_buf       <= '0;
    end else begin
      unique case (1'b1)
        bubble:  ex_to_mem_bus_r <= '0;
        capture: ex_to_mem_bus_r <= ex_to_mem_bus;
        default: ;
      endcase
      // A fresh entry always restarts from live SRAM data.
      if (new_entry) begin
        hold_st <= LIVE;
      end else if (hold_st == LIVE && is_load && stall[4]) begin
        hold_st   <= HELD;
        rdata_buf <= data_sram_rdata;
      end
    end
  end

  assign is_load   = data_ram_en & (data_ram_wen == 4'b0) & sel_rf_res;
  assign rdata_vld = (hold_st == HELD);
  assign load_data = rdata_vld ? rdata_buf : data_sram_rdata;
  assign rf_wdata  = sel_rf_res ? load_data : ex_result;

  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};

`ifdef MEM_FWD_EN
  assign mem_to_id   = {rf_we, rf_waddr, rf_wdata};
  assign mem_is_load = is_load;
`else
  assign mem_to_id   = '0;
  assign mem_is_load = 1'b0;
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage MIPS core, directly downstream of the execute stage. It registers the execute-to-memory bus under stall control and collects load data from the synchronous data SRAM. Load data is held stable across memory-stage stalls. It produces the write-back bus and a forwarding bus toward decode.

## Interface
Parameters:
- EX_TO_MEM_WD, 76 (from `EX_TO_MEM_WD`), width of input bus.
- MEM_TO_WB_WD, 70 (from `MEM_TO_WB_WD`), width of output bus.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- stall  in  `StallBus`  pipeline stall vector; bit 3 = this stage's input register, bit 4 = write-back input register; `Stop`=1.
- ex_to_mem_bus  in  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- data_sram_rdata  in  32  SRAM read data, valid one cycle after the execute-stage request.
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_id  out  38  forwarding bus {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_is_load  out  1  current entry is a load (data_ram_en=1, data_ram_wen=0, sel_rf_res=1).

## Operation
- Input register `ex_to_mem_bus_r`, priority order:
  - rst: clear to 0.
  - stall[3]=Stop and stall[4]=NoStop: load 0 (bubble).
  - stall[3]=NoStop: capture ex_to_mem_bus.
  - otherwise: hold.
- A register update that is not a hold is a new entry.
- Load-data hold buffer:
  - State: `rdata_buf[31:0]` and `rdata_vld`, two states, LIVE (`rdata_vld`=0) and HELD (`rdata_vld`=1).
  - LIVE→HELD: at the end of a cycle with mem_is_load=1 and stall[4]=Stop. Captures `rdata_buf`←data_sram_rdata.
  - HELD→LIVE: when a new entry is loaded (the capture or bubble branch fires), or on rst.
  - HELD→HELD: while stall[4] stays Stop; `rdata_buf` does not update.
  - A new entry always takes priority over capture, so LIVE persists for it.
- `load_data` = `rdata_vld` ? `rdata_buf` : data_sram_rdata.
- rf_wdata = sel_rf_res ? `load_data` : ex_result. Loads are full-word only.
- Stores (data_ram_wen≠0) pass rf_we unchanged. The decoder guarantees rf_we=0 for stores.
- mem_to_wb_bus and mem_is_load are combinational from `ex_to_mem_bus_r` and the hold state.

## Timing
- Reset value of every output is 0. The cleared register yields rf_we=0, pc=0 and rf_wdata=0. This holds from rst assertion, asynchronously.
- Latency: one cycle from ex_to_mem_bus to mem_to_wb_bus. For a load, rf_wdata is valid in the first cycle the entry is in this stage, with no extra wait.
- Bubble: rf_we=0 and pc=0 appear for exactly one cycle per bubble-insert cycle.
- Stall of N cycles with stall[4]=Stop:
  - mem_to_wb_bus is bit-identical for all N+1 cycles.
  - For loads, this holds even if data_sram_rdata changes after the first cycle.
- Simultaneous stall[3]=Stop and stall[4]=Stop: hold. A pending HELD state stays HELD.
- rst mid-stall: the buffer is invalidated and the register cleared in the same instant. The next entry after rst deassertion behaves as fresh.

## Configuration
- `MEM_FWD_EN` defined:
  - mem_to_id = {rf_we, rf_waddr, rf_wdata}, combinational, same cycle as mem_to_wb_bus.
  - mem_is_load is driven as specified.
- `MEM_FWD_EN` undefined:
  - mem_to_id and mem_is_load are tied to 0.
  - Decode must resolve memory-stage hazards by stalling.
  - All other behaviour is unchanged.

## Test plan
- Reset during traffic:
  - Stimulus: assert rst asynchronously between edges with a load entry present.
  - Required: mem_to_wb_bus=0, mem_to_id=0 and mem_is_load=0 before the next edge; the first entry after release uses live rdata.
- ALU pass-through:
  - Stimulus: entry pc=0xBFC00010, rf_we=1, waddr=5, ex_result=0x1234, sel_rf_res=0.
  - Required: next cycle mem_to_wb_bus = {0xBFC00010, 1, 5, 0x1234}; mem_to_id = {1, 5, 0x1234} with MEM_FWD_EN.
- Load, no stall:
  - Stimulus: load entry, waddr=8, data_sram_rdata=0xDEADBEEF in its MEM cycle.
  - Required: rf_wdata=0xDEADBEEF and mem_is_load=1 for one cycle.
- Load with stall[4]=Stop for 3 cycles:
  - Stimulus: rdata 0xCAFEF00D in the first cycle, then 0x0 and 0x55555555.
  - Required: rf_wdata=0xCAFEF00D in all 4 cycles.
- Bubble insert:
  - Stimulus: stall[3]=1, stall[4]=0 for one cycle after a valid entry.
  - Required: next cycle rf_we=0, pc=0, rf_wdata=0.
- Hold:
  - Stimulus: stall[3]=1 and stall[4]=1 for 2 cycles while ex_to_mem_bus changes.
  - Required: outputs unchanged; capture resumes the cycle after stall[3]=0.
